// File: rtl/arb_grant_fifo_if.sv
// ---------------------------------------------------------------------------
// arb_grant_fifo_if
//   Bundles the arbiter-side accept handshake and the consumer-side
//   valid/ready handshake of arb_grant_fifo into one interface.
//
//   Arbiter side : arb_req (req_o of arbiter), arb_grant (one-hot ack_i),
//                  in_data (N words of W bits), arb_ack (back to ack_o).
//   Consumer side: out_valid/out_ready handshake, out_data, out_src.
//   Status       : count (occupancy), err_grant (sticky protocol error).
//
//   slave  : view taken by the FIFO itself.
//   master : view taken by whoever drives the arbiter/consumer signals.
// ---------------------------------------------------------------------------
interface arb_grant_fifo_if #(
    parameter int N     = 8,
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int SW    = $clog2(N)
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              arb_req;
    logic              arb_ack;
    logic [N-1:0]      arb_grant;
    logic [N*W-1:0]    in_data;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [SW-1:0]     out_src;
    logic [CW-1:0]     count;
    logic              err_grant;

    modport slave (
        input  arb_req, arb_grant, in_data, out_ready,
        output arb_ack, out_valid, out_data, out_src, count, err_grant
    );

    modport master (
        output arb_req, arb_grant, in_data, out_ready,
        input  arb_ack, out_valid, out_data, out_src, count, err_grant
    );
endinterface

// File: rtl/arb_grant_fifo.sv
// ---------------------------------------------------------------------------
// arb_grant_fifo
//   Downstream stage of an N-way arbiter. On each accepted grant it selects
//   the granted requester's word, tags it with the encoded source index and
//   pushes both into a DEPTH-entry first-word-fall-through FIFO whose head is
//   offered to a single consumer over valid/ready.
//
//   Ports:
//     clk  - rising-edge clock
//     rstn - asynchronous active-low reset
//     bus  - arb_grant_fifo_if.slave (arbiter handshake, data in,
//            consumer handshake, occupancy and sticky grant-error flag)
//
//   arb_ack depends only on registered state, so there is no combinational
//   path from the arbiter's grant back into its own ack input.
// ---------------------------------------------------------------------------
module arb_grant_fifo #(
    parameter int N     = 8,
    parameter int W     = 32,
    parameter int DEPTH = 4,
    parameter int SW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rstn,
    arb_grant_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [SW-1:0] src;
        logic [W-1:0]  data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          en_q;
    logic          err_q, err_d;

    logic          not_full;
    logic          not_empty;
    logic          handshake;
    logic          grant_onehot;
    logic          wr_en;
    logic          rd_en;
    entry_t        sel_entry;

    assign not_full  = (count_q != CW'(DEPTH));
    assign not_empty = (count_q != '0);

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves 0.
    assign grant_onehot = (bus.arb_grant != '0) &&
                          ((bus.arb_grant & (bus.arb_grant - N'(1))) == '0);

    assign bus.arb_ack = en_q & not_full;
    assign handshake   = bus.arb_req & bus.arb_ack;
    assign wr_en       = handshake & grant_onehot;
    assign rd_en       = not_empty & bus.out_ready;

    // AND-OR mux and encoder; only meaningful when the grant is one-hot.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel_entry = '0;
        for (int i = 0; i < N; i++) begin
            sel_entry.data = sel_entry.data | (bus.in_data[i*W +: W] & {W{bus.arb_grant[i]}});
            if (bus.arb_grant[i]) begin
                sel_entry.src = sel_entry.src | SW'(i);
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (handshake & ~grant_onehot);

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            en_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            en_q     <= 1'b1;
            err_q    <= err_d;
        end
    end

    // NOTE: storage has no reset; out_valid (count) gates whether its content means anything.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sel_entry;
        end
    end

    assign bus.out_valid = not_empty;
    assign bus.out_data  = mem_q[rd_ptr_q].data;
    assign bus.out_src   = mem_q[rd_ptr_q].src;
    assign bus.count     = count_q;
    assign bus.err_grant = err_q;

endmodule

// File: tb/tb_arb_grant_fifo.sv
// ---------------------------------------------------------------------------
// tb_arb_grant_fifo
//   Bench for arb_grant_fifo with N=4, W=8, DEPTH=4. Hand-written vector
//   table and directed sequences, followed by randomized traffic compared
//   against a queue-based reference model of the FIFO.
// ---------------------------------------------------------------------------
module tb_arb_grant_fifo;
    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int SW    = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    arb_grant_fifo_if #(.N(N), .W(W), .DEPTH(DEPTH), .SW(SW)) bus ();

    arb_grant_fifo #(.N(N), .W(W), .DEPTH(DEPTH), .SW(SW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [SW-1:0] src;
        logic [W-1:0]  data;
    } ent_t;

    ent_t mq[$];
    bit   m_en;
    bit   m_err;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_en  = 1'b0;
        m_err = 1'b0;
    endtask

    // Compare every DUT output with what the model says right now.
    task automatic compare_model(input string tag);
        check({tag, ".ack"},   32'(bus.arb_ack),   32'(m_en && mq.size() < DEPTH));
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(mq.size() != 0));
        check({tag, ".count"}, 32'(bus.count),     32'(mq.size()));
        check({tag, ".err"},   32'(bus.err_grant), 32'(m_err));
        if (mq.size() != 0) begin
            check({tag, ".data"}, 32'(bus.out_data), 32'(mq[0].data));
            check({tag, ".src"},  32'(bus.out_src),  32'(mq[0].src));
        end
    endtask

    // Drive one cycle of inputs; the word goes into every granted slot,
    // all other slots get random filler so the mux is exercised.
    task automatic set_in(input logic req, input logic [N-1:0] grant,
                          input logic [W-1:0] word, input logic ready);
        logic [N*W-1:0] d;
        d = N*W'($urandom);
        for (int i = 0; i < N; i++) begin
            if (grant[i]) d[i*W +: W] = word;
        end
        bus.arb_req   = req;
        bus.arb_grant = grant;
        bus.in_data   = d;
        bus.out_ready = ready;
    endtask

    // Advance one clock edge and update the model from the applied inputs.
    task automatic tick();
        int   ones;
        bit   acc, wr, rd;
        ent_t e;
        ones = $countones(bus.arb_grant);
        acc  = m_en && (mq.size() < DEPTH);
        wr   = bus.arb_req && acc && (ones == 1);
        rd   = (mq.size() != 0) && bus.out_ready;
        e    = '0;
        if (wr) begin
            for (int i = 0; i < N; i++) begin
                if (bus.arb_grant[i]) begin
                    e.src  = SW'(i);
                    e.data = bus.in_data[i*W +: W];
                end
            end
        end
        @(posedge clk);
        #1;
        if (bus.arb_req && acc && (ones != 1)) m_err = 1'b1;
        if (rd) void'(mq.pop_front());
        if (wr) mq.push_back(e);
        m_en = 1'b1;
    endtask

    task automatic do_reset();
        set_in(1'b0, '0, '0, 1'b0);
        rstn = 1'b0;
        model_clear();
        #1;
        check("rst.ack",   32'(bus.arb_ack),   32'd0);
        check("rst.valid", 32'(bus.out_valid), 32'd0);
        check("rst.count", 32'(bus.count),     32'd0);
        check("rst.err",   32'(bus.err_grant), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rel.ack_first", 32'(bus.arb_ack), 32'd0);
        tick();
        check("rel.ack_next",  32'(bus.arb_ack),   32'd1);
        check("rel.valid",     32'(bus.out_valid), 32'd0);
        check("rel.count",     32'(bus.count),     32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          req;
        logic [N-1:0]  grant;
        logic [W-1:0]  word;
        logic          ready;
        int            exp_cnt;
        logic          exp_ack;
        logic [W-1:0]  exp_data;
        logic [SW-1:0] exp_src;
    } vec_t;

    vec_t vt[11];

    initial begin
        // single transfer, then fill to full, blocked 5th request,
        // read while full, drain in order
        vt[0]  = '{1'b1, 4'b0100, 8'hA5, 1'b0, 1, 1'b1, 8'hA5, 2'd2};
        vt[1]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 0, 1'b1, 8'h00, 2'd0};
        vt[2]  = '{1'b1, 4'b0001, 8'h11, 1'b0, 1, 1'b1, 8'h11, 2'd0};
        vt[3]  = '{1'b1, 4'b0010, 8'h22, 1'b0, 2, 1'b1, 8'h11, 2'd0};
        vt[4]  = '{1'b1, 4'b0100, 8'h33, 1'b0, 3, 1'b1, 8'h11, 2'd0};
        vt[5]  = '{1'b1, 4'b1000, 8'h44, 1'b0, 4, 1'b0, 8'h11, 2'd0};
        vt[6]  = '{1'b1, 4'b0001, 8'h55, 1'b0, 4, 1'b0, 8'h11, 2'd0};
        vt[7]  = '{1'b1, 4'b0001, 8'h55, 1'b1, 3, 1'b1, 8'h22, 2'd1};
        vt[8]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 2, 1'b1, 8'h33, 2'd2};
        vt[9]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 1, 1'b1, 8'h44, 2'd3};
        vt[10] = '{1'b0, 4'b0000, 8'h00, 1'b1, 0, 1'b1, 8'h00, 2'd0};

        do_reset();

        for (int v = 0; v < 11; v++) begin
            set_in(vt[v].req, vt[v].grant, vt[v].word, vt[v].ready);
            tick();
            check($sformatf("vec%0d.count", v), 32'(bus.count),     32'(vt[v].exp_cnt));
            check($sformatf("vec%0d.valid", v), 32'(bus.out_valid), 32'(vt[v].exp_cnt != 0));
            check($sformatf("vec%0d.ack", v),   32'(bus.arb_ack),   32'(vt[v].exp_ack));
            if (vt[v].exp_cnt != 0) begin
                check($sformatf("vec%0d.data", v), 32'(bus.out_data), 32'(vt[v].exp_data));
                check($sformatf("vec%0d.src", v),  32'(bus.out_src),  32'(vt[v].exp_src));
            end
            compare_model($sformatf("vec%0d.model", v));
        end

        // ---- steady stream: write and read every cycle, pointers wrap ----
        set_in(1'b1, 4'b0001, 8'd0, 1'b0);
        tick();
        check("stream.first_count", 32'(bus.count),    32'd1);
        check("stream.first_data",  32'(bus.out_data), 32'd0);
        for (int k = 1; k < 10; k++) begin
            set_in(1'b1, N'(1) << (k % N), W'(k), 1'b1);
            check($sformatf("stream%0d.head_pre", k), 32'(bus.out_data), 32'(k - 1));
            tick();
            check($sformatf("stream%0d.count", k), 32'(bus.count),    32'd1);
            check($sformatf("stream%0d.data", k),  32'(bus.out_data), 32'(k));
            check($sformatf("stream%0d.src", k),   32'(bus.out_src),  32'(k % N));
        end
        set_in(1'b0, '0, '0, 1'b1);
        tick();
        check("stream.drain_count", 32'(bus.count),     32'd0);
        check("stream.drain_valid", 32'(bus.out_valid), 32'd0);

        // ---- out_ready ignored while empty ----
        set_in(1'b0, '0, '0, 1'b1);
        tick();
        check("empty_ready.count", 32'(bus.count), 32'd0);

        // ---- bad grants: multi-bit then zero ----
        set_in(1'b1, 4'b0110, 8'h77, 1'b0);
        check("bad.ack_pre", 32'(bus.arb_ack), 32'd1);
        tick();
        check("bad.multi_count", 32'(bus.count),     32'd0);
        check("bad.multi_err",   32'(bus.err_grant), 32'd1);
        set_in(1'b1, 4'b0000, 8'h00, 1'b0);
        tick();
        check("bad.zero_count", 32'(bus.count),     32'd0);
        check("bad.zero_err",   32'(bus.err_grant), 32'd1);
        set_in(1'b1, 4'b1000, 8'h9C, 1'b0);
        tick();
        check("bad.after_count", 32'(bus.count),     32'd1);
        check("bad.after_data",  32'(bus.out_data),  32'h9C);
        check("bad.after_src",   32'(bus.out_src),   32'd3);
        check("bad.sticky_err",  32'(bus.err_grant), 32'd1);
        compare_model("bad.model");

        // reset clears err_grant and discards the stored word
        do_reset();
        check("bad.err_cleared", 32'(bus.err_grant), 32'd0);

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] g;
            if ($urandom_range(0, 24) == 0) g = N'($urandom);
            else                            g = N'(1) << $urandom_range(0, N - 1);
            bus.arb_req   = ($urandom_range(0, 3) != 0);
            bus.arb_grant = g;
            bus.in_data   = N*W'($urandom);
            bus.out_ready = ($urandom_range(0, 1) == 1);
            tick();
            compare_model($sformatf("rnd%0d", c));

            if (c == 200) begin
                // asynchronous reset in the middle of a cycle
                #2;
                rstn = 1'b0;
                #1;
                check("midrst.valid", 32'(bus.out_valid), 32'd0);
                check("midrst.count", 32'(bus.count),     32'd0);
                check("midrst.ack",   32'(bus.arb_ack),   32'd0);
                check("midrst.err",   32'(bus.err_grant), 32'd0);
                model_clear();
                @(negedge clk);
                rstn = 1'b1;
                #1;
                check("midrst.ack_first", 32'(bus.arb_ack), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
